multiplier_core: RTL and testbench

Parameterised unsigned integer multiplier for the 8-bit ALU datapath. It computes c = a × b with a full double-width product using an iterative shift-and-add algorithm, one multiplier bit per clock. A start/busy/done handshake lets the ALU control sequencer launch an operation and collect the result.

---
 rtl/alu_pkg.sv | 17 +
 rtl/multiplier_core_if.sv | 16 +
 rtl/multiplier_core_datapath.sv | 51 +++++
 rtl/multiplier_core.sv | 106 ++++++++++
 tb/tb_multiplier_core.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU datapath blocks.
// Holds the multiplier FSM state encoding and the iteration-counter width helper.
package alu_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEFAULT_SIZE = 8;

  // Counter wide enough to hold the value SIZE itself.
  function automatic int cnt_width(input int size);
    return $clog2(size + 1);
  endfunction

endpackage

// File: rtl/multiplier_core_if.sv
// Start/busy/done handshake and operand/result bus between the ALU sequencer and the multiplier.
interface multiplier_core_if #(
  parameter int SIZE = alu_pkg::DEFAULT_SIZE
);

  logic              start;
  logic [SIZE-1:0]   a;
  logic [SIZE-1:0]   b;
  logic              busy;
  logic              done;
  logic [2*SIZE-1:0] c;

  modport master (output start, a, b, input busy, done, c);
  modport slave  (input start, a, b, output busy, done, c);

endinterface

// File: rtl/multiplier_core_datapath.sv
// Shift-and-add datapath: multiplicand/multiplier shift registers and the product accumulator.
// acc_next is the accumulator value after the current step, used by the top to capture the final product.
module mult_datapath
  import alu_pkg::*;
#(
  parameter int SIZE = DEFAULT_SIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [SIZE-1:0]   a,
  input  logic [SIZE-1:0]   b,
  output logic [2*SIZE-1:0] acc_next
);

  logic [2*SIZE-1:0] mcand_r;
  logic [SIZE-1:0]   mplier_r;
  logic [2*SIZE-1:0] acc_r;
  logic [2*SIZE-1:0] acc_sum_s;

  // Conditional add of the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    acc_sum_s = acc_r;
    if (mplier_r[0]) begin
      acc_sum_s = acc_r + mcand_r;
    end else begin
      acc_sum_s = acc_r;
    end
  end

  assign acc_next = acc_sum_s;

  // Operand capture on load, then one multiplier bit consumed per step.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_r  <= {(2*SIZE){1'b0}};
      mplier_r <= {SIZE{1'b0}};
      acc_r    <= {(2*SIZE){1'b0}};
    end else if (load) begin
      mcand_r  <= {{SIZE{1'b0}}, a};
      mplier_r <= b;
      acc_r    <= {(2*SIZE){1'b0}};
    end else if (step) begin
      mcand_r  <= {mcand_r[2*SIZE-2:0], 1'b0};
      mplier_r <= {1'b0, mplier_r[SIZE-1:1]};
      acc_r    <= acc_sum_s;
    end
  end

endmodule

// File: rtl/multiplier_core.sv
// Iterative unsigned multiplier: FSM, iteration counter and registered busy/done/c outputs.
// A start in the done cycle is accepted, giving one product every SIZE+1 cycles.
module multiplier_core
  import alu_pkg::*;
#(
  parameter int SIZE = DEFAULT_SIZE
) (
  input  logic               clk,
  input  logic               rst,
  multiplier_core_if.slave   bus
);

  localparam int CW = cnt_width(SIZE);
  localparam logic [CW-1:0] LAST_CNT = CW'(SIZE - 1);

  state_t            state_r;
  state_t            state_s;
  logic              load_s;
  logic              step_s;
  logic              last_s;
  logic [CW-1:0]     count_r;
  logic              busy_r;
  logic              done_r;
  logic [2*SIZE-1:0] c_r;
  logic [2*SIZE-1:0] acc_next_s;

  mult_datapath #(.SIZE(SIZE)) u_datapath (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .step     (step_s),
    .a        (bus.a),
    .b        (bus.b),
    .acc_next (acc_next_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    step_s  = 1'b0;
    last_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          load_s  = 1'b1;
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        step_s = 1'b1;
        if (count_r == LAST_CNT) begin
          last_s  = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = RUN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Iteration counter: cleared on load, advanced on every step.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {CW{1'b0}};
    end else if (load_s) begin
      count_r <= {CW{1'b0}};
    end else if (step_s) begin
      count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // Output registers; c only moves on the final step so it holds through RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      c_r    <= {(2*SIZE){1'b0}};
    end else begin
      busy_r <= (state_s == RUN);
      done_r <= last_s;
      if (last_s) begin
        c_r <= acc_next_s;
      end
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.c    = c_r;

endmodule

// File: tb/tb_multiplier_core.sv
// Directed scoreboard bench for multiplier_core at SIZE=4 and SIZE=8.
module tb_multiplier_core;

  logic clk;
  logic rst4;
  logic rst8;
  int   total;
  int   bad;
  logic [7:0]  q4[$];
  logic [15:0] q8[$];
  logic [7:0]  prev4;
  logic [15:0] prev8;

  multiplier_core_if #(.SIZE(4)) bus4 ();
  multiplier_core_if #(.SIZE(8)) bus8 ();

  multiplier_core #(.SIZE(4)) dut4 (.clk(clk), .rst(rst4), .bus(bus4));
  multiplier_core #(.SIZE(8)) dut8 (.clk(clk), .rst(rst8), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic go4(input logic [3:0] x, input logic [3:0] y);
    bus4.a     = x;
    bus4.b     = y;
    bus4.start = 1'b1;
    q4.push_back({4'b0000, x} * {4'b0000, y});
  endtask

  task automatic go8(input logic [7:0] x, input logic [7:0] y);
    bus8.a     = x;
    bus8.b     = y;
    bus8.start = 1'b1;
    q8.push_back({8'h00, x} * {8'h00, y});
  endtask

  // Waits (bounded) for done, checking c holds, latency, product and one-cycle done.
  task automatic collect4(input int lat);
    int n;
    logic [7:0] exp;
    n = 0;
    while (bus4.done !== 1'b1 && n < 40) begin
      chk("c4_hold", 64'(bus4.c), 64'(prev4));
      tick();
      n++;
    end
    chk("lat4", 64'(n), 64'(lat));
    chk("done4", 64'(bus4.done), 64'd1);
    chk("busy4_at_done", 64'(bus4.busy), 64'd0);
    exp = q4.pop_front();
    chk("c4", 64'(bus4.c), 64'(exp));
    prev4 = exp;
    tick();
    chk("done4_pulse", 64'(bus4.done), 64'd0);
  endtask

  task automatic collect8(input int lat);
    int n;
    logic [15:0] exp;
    n = 0;
    while (bus8.done !== 1'b1 && n < 40) begin
      chk("c8_hold", 64'(bus8.c), 64'(prev8));
      tick();
      n++;
    end
    chk("lat8", 64'(n), 64'(lat));
    chk("done8", 64'(bus8.done), 64'd1);
    chk("busy8_at_done", 64'(bus8.busy), 64'd0);
    exp = q8.pop_front();
    chk("c8", 64'(bus8.c), 64'(exp));
    prev8 = exp;
    tick();
    chk("done8_pulse", 64'(bus8.done), 64'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    prev4 = 8'h00;
    prev8 = 16'h0000;
    rst4 = 1'b1;
    rst8 = 1'b1;
    bus4.start = 1'b0; bus4.a = 4'h0; bus4.b = 4'h0;
    bus8.start = 1'b0; bus8.a = 8'h00; bus8.b = 8'h00;
    tick();
    tick();
    rst4 = 1'b0;
    rst8 = 1'b0;
    chk("rst_busy4", 64'(bus4.busy), 64'd0);
    chk("rst_done4", 64'(bus4.done), 64'd0);
    chk("rst_c4", 64'(bus4.c), 64'd0);
    chk("rst_busy8", 64'(bus8.busy), 64'd0);
    chk("rst_done8", 64'(bus8.done), 64'd0);
    chk("rst_c8", 64'(bus8.c), 64'd0);

    // SIZE=4: a=15 against a sweep of b values.
    begin
      logic [3:0] bv [6];
      bv = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd9};
      for (int i = 0; i < 6; i++) begin
        go4(4'hF, bv[i]);
        tick();
        bus4.start = 1'b0;
        chk("busy4_after_start", 64'(bus4.busy), 64'd1);
        collect4(4);
      end
    end

    // SIZE=8: full-scale operands, then a zero multiplicand.
    go8(8'd255, 8'd255);
    tick();
    bus8.start = 1'b0;
    collect8(8);

    // Reset mid-run aborts: no done, c cleared.
    rst8 = 1'b1;
    tick();
    rst8 = 1'b0;
    chk("rst2_busy8", 64'(bus8.busy), 64'd0);
    chk("rst2_done8", 64'(bus8.done), 64'd0);
    chk("rst2_c8", 64'(bus8.c), 64'd0);
    prev8 = 16'h0000;
    bus8.a = 8'd12;
    bus8.b = 8'd10;
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    tick();
    tick();
    rst8 = 1'b1;
    tick();
    rst8 = 1'b0;
    chk("abort_busy8", 64'(bus8.busy), 64'd0);
    chk("abort_c8", 64'(bus8.c), 64'd0);
    for (int i = 0; i < 10; i++) begin
      chk("abort_no_done8", 64'(bus8.done), 64'd0);
      tick();
    end
    go8(8'd12, 8'd10);
    tick();
    bus8.start = 1'b0;
    collect8(8);
    go8(8'd0, 8'd200);
    tick();
    bus8.start = 1'b0;
    collect8(8);

    // start while busy is ignored and operand changes mid-run have no effect.
    go8(8'd5, 8'd7);
    tick();
    bus8.start = 1'b0;
    chk("busy8_after_start", 64'(bus8.busy), 64'd1);
    tick();
    bus8.a = 8'd3;
    bus8.b = 8'd3;
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    bus8.a = 8'd200;
    bus8.b = 8'd100;
    collect8(6);
    for (int i = 0; i < 12; i++) begin
      chk("no_extra_done8", 64'(bus8.done), 64'd0);
      tick();
    end
    chk("c8_after_ignored", 64'(bus8.c), 64'd35);

    // Back-to-back with start held high: second op accepted in the done cycle.
    go4(4'd6, 4'd7);
    tick();
    bus4.a = 4'd9;
    bus4.b = 4'd9;
    q4.push_back(8'd81);
    collect4(4);
    bus4.start = 1'b0;
    chk("busy4_second_run", 64'(bus4.busy), 64'd1);
    collect4(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
